// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter and sequencer for a shared 4:1 mux output path.
// One source owns the select at a time. It keeps ownership for up to MAX_HOLD
// accepted beats, or until it drops its request. Priority then rotates to the
// next index. Every release costs one IDLE cycle before the next owner is
// chosen. The consumer side uses a valid/ready handshake. The grant output is
// a one-hot accept strobe to the owning source.
module rr_mux_arbiter4 #(
  parameter int WIDTH    = 32,
  // Legal range is 1..255; the beat counter is 8 bits wide.
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  output logic [3:0]       grant
);

  // Counter value at which the next accepted beat is the last one allowed.
  localparam logic [7:0] LAST_CNT = 8'(MAX_HOLD - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           state_q;
  logic [1:0]       sel_q;     // current owner / mux select
  logic [1:0]       ptr_q;     // highest-priority index for the next pick
  logic [7:0]       cnt_q;     // beats accepted under the current grant

  logic             in_grant;
  logic             owner_req;
  logic             accept;
  logic             last_beat;
  logic             rel_grant;
  logic [WIDTH-1:0] mux_data;

  // First requester found when scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // The loop walks from the farthest offset down, so the nearest hit wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign in_grant  = (state_q == ST_GRANT);
  assign owner_req = req[sel_q];
  assign out_valid = in_grant & owner_req;
  assign accept    = out_valid & out_ready;
  assign last_beat = (cnt_q == LAST_CNT);

  // Release after the final permitted beat is accepted, or when the owner
  // withdraws its request. A dropped request never coincides with an accept,
  // because out_valid follows the request.
  assign rel_grant = (accept & last_beat) | (in_grant & ~owner_req);

  // Shared 4:1 data mux driven by the registered select.
  always_comb begin
    mux_data = data_a;
    case (sel_q)
      2'd0:    mux_data = data_a;
      2'd1:    mux_data = data_b;
      2'd2:    mux_data = data_c;
      default: mux_data = data_d;
    endcase
  end

  // Outputs are zero when no beat is offered. out_src comes straight from the
  // select register, so it cannot glitch.
  assign out_data = out_valid ? mux_data : '0;
  assign out_src  = sel_q;
  assign grant    = accept ? (4'b0001 << sel_q) : 4'b0000;

  // Arbitration FSM: choose an owner in IDLE, count beats in GRANT, then rotate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            sel_q   <= rr_pick(req, ptr_q);
            cnt_q   <= 8'd0;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (rel_grant) begin
            state_q <= ST_IDLE;
            ptr_q   <= sel_q + 2'd1;
            cnt_q   <= 8'd0;
          end else if (accept) begin
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Testbench for rr_mux_arbiter4. Two instances share one stimulus stream:
// one with MAX_HOLD=4 and one with MAX_HOLD=1. An ownership-level model
// predicts both instances and is compared on every falling edge. Directed
// literal expectations pin the model.
module tb_rr_mux_arbiter4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req   = 4'b0000;
  logic [31:0] da = '0, db = '0, dc = '0, dd = '0;
  logic        rdy   = 1'b0;

  logic        v4, v1;
  logic [31:0] d4, d1;
  logic [1:0]  s4, s1;
  logic [3:0]  g4, g1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter4 #(.WIDTH(32), .MAX_HOLD(4)) dut4 (
    .clk(clk), .reset(reset), .req(req),
    .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
    .out_ready(rdy), .out_valid(v4), .out_data(d4), .out_src(s4), .grant(g4)
  );

  rr_mux_arbiter4 #(.WIDTH(32), .MAX_HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .req(req),
    .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
    .out_ready(rdy), .out_valid(v1), .out_data(d1), .out_src(s1), .grant(g1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ownership model ----------------
  // owner = -1 means nobody holds the path. beats counts accepted beats.
  int m_owner[2] = '{-1, -1};
  int m_prio[2]  = '{0, 0};
  int m_beats[2] = '{0, 0};
  int m_src[2]   = '{0, 0};

  function automatic int hold_of(input int n);
    return (n == 0) ? 4 : 1;
  endfunction

  function automatic int first_req(input int p);
    int pick;
    pick = -1;
    for (int k = 0; k < 4; k++)
      if (pick < 0 && req[2'((p + k) % 4)]) pick = (p + k) % 4;
    return pick;
  endfunction

  function automatic logic [31:0] src_data(input int i);
    case (i)
      0:       return da;
      1:       return db;
      2:       return dc;
      default: return dd;
    endcase
  endfunction

  function automatic logic exp_valid(input int n);
    if (m_owner[n] < 0) return 1'b0;
    return req[2'(m_owner[n])];
  endfunction

  function automatic logic [31:0] exp_data(input int n);
    return exp_valid(n) ? src_data(m_owner[n]) : 32'h0;
  endfunction

  function automatic logic [3:0] exp_grant(input int n);
    return (exp_valid(n) && rdy) ? 4'(1 << m_owner[n]) : 4'b0000;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        m_owner[n] <= -1;
        m_prio[n]  <= 0;
        m_beats[n] <= 0;
        m_src[n]   <= 0;
      end else if (m_owner[n] < 0) begin
        if (req != 4'b0000) begin
          m_owner[n] <= first_req(m_prio[n]);
          m_src[n]   <= first_req(m_prio[n]);
          m_beats[n] <= 0;
        end
      end else if (req[2'(m_owner[n])] && rdy) begin
        if (m_beats[n] + 1 == hold_of(n)) begin
          m_owner[n] <= -1;
          m_prio[n]  <= (m_owner[n] + 1) % 4;
          m_beats[n] <= 0;
        end else begin
          m_beats[n] <= m_beats[n] + 1;
        end
      end else if (!req[2'(m_owner[n])]) begin
        m_owner[n] <= -1;
        m_prio[n]  <= (m_owner[n] + 1) % 4;
        m_beats[n] <= 0;
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    chk("mdl4.valid", 32'(v4), 32'(exp_valid(0)));
    chk("mdl4.data",  d4,      exp_data(0));
    chk("mdl4.src",   32'(s4), 32'(m_src[0]));
    chk("mdl4.grant", 32'(g4), 32'(exp_grant(0)));
    chk("mdl1.valid", 32'(v1), 32'(exp_valid(1)));
    chk("mdl1.data",  d1,      exp_data(1));
    chk("mdl1.src",   32'(s1), 32'(m_src[1]));
    chk("mdl1.grant", 32'(g1), 32'(exp_grant(1)));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input int n, input logic v, input logic [1:0] s,
                      input logic [3:0] g, input logic [31:0] d, input string tag);
    #1;
    chk({tag, ".valid"}, 32'(n ? v1 : v4), 32'(v));
    chk({tag, ".src"},   32'(n ? s1 : s4), 32'(s));
    chk({tag, ".grant"}, 32'(n ? g1 : g4), 32'(g));
    chk({tag, ".data"},  n ? d1 : d4,      d);
  endtask

  task automatic do_rst();
    tick();
    reset = 1'b1;
    req   = 4'b0000;
    rdy   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] dv[4];

  initial begin
    #1 reset = 1'b1;
    tick();
    look(0, 1'b0, 2'd0, 4'b0000, 32'h0, "reset4");
    look(1, 1'b0, 2'd0, 4'b0000, 32'h0, "reset1");

    // Single source 1: four beats, one bubble, then a regrant.
    do_rst();
    db = 32'hDEADBEEF; req = 4'b0010; rdy = 1'b1;
    look(0, 1'b0, 2'd0, 4'b0000, 32'h0, "t1.idle");
    for (int b = 0; b < 4; b++) begin
      tick();
      look(0, 1'b1, 2'd1, 4'b0010, 32'hDEADBEEF, "t1.beat");
    end
    tick();
    look(0, 1'b0, 2'd1, 4'b0000, 32'h0, "t1.gap");
    tick();
    look(0, 1'b1, 2'd1, 4'b0010, 32'hDEADBEEF, "t1.regrant");

    // Round robin with all four requesting.
    do_rst();
    dv[0] = 32'hA0A0A0A0; dv[1] = 32'hB1B1B1B1; dv[2] = 32'hC2C2C2C2; dv[3] = 32'hD3D3D3D3;
    da = dv[0]; db = dv[1]; dc = dv[2]; dd = dv[3];
    req = 4'b1111; rdy = 1'b1;
    look(0, 1'b0, 2'd0, 4'b0000, 32'h0, "t2.idle");
    for (int o = 0; o < 4; o++) begin
      for (int b = 0; b < 4; b++) begin
        tick();
        look(0, 1'b1, 2'(o), 4'(1 << o), dv[o], "t2.beat");
      end
      tick();
      look(0, 1'b0, 2'(o), 4'b0000, 32'h0, "t2.gap");
    end
    tick();
    look(0, 1'b1, 2'd0, 4'b0001, dv[0], "t2.wrap");

    // Backpressure on source 2.
    do_rst();
    dc = 32'hC0FFEE02; req = 4'b0100; rdy = 1'b0;
    look(0, 1'b0, 2'd0, 4'b0000, 32'h0, "t3.idle");
    tick(); rdy = 1'b1; look(0, 1'b1, 2'd2, 4'b0100, 32'hC0FFEE02, "t3.r1");
    tick(); rdy = 1'b0; look(0, 1'b1, 2'd2, 4'b0000, 32'hC0FFEE02, "t3.stall1");
    tick();             look(0, 1'b1, 2'd2, 4'b0000, 32'hC0FFEE02, "t3.stall2");
    tick(); rdy = 1'b1; look(0, 1'b1, 2'd2, 4'b0100, 32'hC0FFEE02, "t3.r2");
    tick();             look(0, 1'b1, 2'd2, 4'b0100, 32'hC0FFEE02, "t3.r3");
    tick();             look(0, 1'b1, 2'd2, 4'b0100, 32'hC0FFEE02, "t3.r4");
    tick();             look(0, 1'b0, 2'd2, 4'b0000, 32'h0, "t3.gap");

    // Early drop by source 3, ptr wraps to 0.
    do_rst();
    da = 32'h0A0A0A0A; dd = 32'hD0D0D0D3; req = 4'b1000; rdy = 1'b1;
    look(0, 1'b0, 2'd0, 4'b0000, 32'h0, "t4.idle");
    tick(); req = 4'b1001; look(0, 1'b1, 2'd3, 4'b1000, 32'hD0D0D0D3, "t4.b1");
    tick();                look(0, 1'b1, 2'd3, 4'b1000, 32'hD0D0D0D3, "t4.b2");
    tick(); req = 4'b0001; look(0, 1'b0, 2'd3, 4'b0000, 32'h0, "t4.drop");
    tick();                look(0, 1'b0, 2'd3, 4'b0000, 32'h0, "t4.bubble");
    tick();                look(0, 1'b1, 2'd0, 4'b0001, 32'h0A0A0A0A, "t4.next");

    // Asynchronous reset during beat 2 of source 1.
    do_rst();
    db = 32'h5A5A0001; req = 4'b0010; rdy = 1'b1;
    look(0, 1'b0, 2'd0, 4'b0000, 32'h0, "t5.idle");
    tick(); look(0, 1'b1, 2'd1, 4'b0010, 32'h5A5A0001, "t5.b1");
    tick(); look(0, 1'b1, 2'd1, 4'b0010, 32'h5A5A0001, "t5.b2");
    #1 reset = 1'b1;
    look(0, 1'b0, 2'd0, 4'b0000, 32'h0, "t5.async4");
    chk("t5.async1.valid", 32'(v1), 32'h0);
    chk("t5.async1.grant", 32'(g1), 32'h0);
    tick(); reset = 1'b0; req = 4'b0110;
    look(0, 1'b0, 2'd0, 4'b0000, 32'h0, "t5.idle2");
    tick(); look(0, 1'b1, 2'd1, 4'b0010, 32'h5A5A0001, "t5.first");

    // MAX_HOLD=1 instance: per-beat alternation between sources 0 and 2.
    do_rst();
    da = 32'h11110000; dc = 32'h22220002; req = 4'b0101; rdy = 1'b1;
    look(1, 1'b0, 2'd0, 4'b0000, 32'h0, "t6.idle");
    for (int i = 0; i < 4; i++) begin
      tick();
      look(1, 1'b1, 2'((i % 2) * 2), (i % 2) ? 4'b0100 : 4'b0001,
           (i % 2) ? 32'h22220002 : 32'h11110000, "t6.beat");
      tick();
      look(1, 1'b0, 2'((i % 2) * 2), 4'b0000, 32'h0, "t6.gap");
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
